// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: opcode constants, hazard FSM state type
// and a small opcode helper.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam int unsigned HZ_CNT_W = $clog2(8);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    CTRL_STALL = 2'd2
  } hz_state_e;

  // JAL is excluded: its target is resolved in ID, so it never holds fetch.
  function automatic logic is_ctrl_opc(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/hazard_down_counter.sv
// Loadable down-counter holding the remaining stall cycles; done flags the
// last cycle of a multi-cycle stall (count == 1).
module hazard_down_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         done
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == W'(1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard detection and pipeline control beside ID: load-use bubbles,
// control-hazard fetch holds (or redirect flush) and a stall-cycle counter.
module hazard_ctrl_unit
  import riscv_pkg::*;
#(
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CTRL_STALL_CYC = 2,
  parameter int unsigned BR_MODE        = 0,
  parameter int unsigned PERF_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cnt
);

  if (REG_AW < 1) begin : g_bad_reg_aw
    $fatal(1, "hazard_ctrl_unit: REG_AW must be at least 1");
  end
  if ((LOAD_STALL_CYC < 1) || (LOAD_STALL_CYC > 7)) begin : g_bad_load_cyc
    $fatal(1, "hazard_ctrl_unit: LOAD_STALL_CYC must be 1..7");
  end
  if ((CTRL_STALL_CYC < 1) || (CTRL_STALL_CYC > 7)) begin : g_bad_ctrl_cyc
    $fatal(1, "hazard_ctrl_unit: CTRL_STALL_CYC must be 1..7");
  end
  if (BR_MODE > 1) begin : g_bad_br_mode
    $fatal(1, "hazard_ctrl_unit: BR_MODE must be 0 or 1");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $fatal(1, "hazard_ctrl_unit: PERF_W must be at least 1");
  end

  localparam logic                LOAD_MULTI  = (LOAD_STALL_CYC > 1);
  localparam logic                CTRL_MULTI  = (CTRL_STALL_CYC > 1);
  localparam logic                STALL_ON_BR = (BR_MODE == 0);
  localparam logic                PREDICT_NT  = (BR_MODE == 1);
  localparam logic [HZ_CNT_W-1:0] LOAD_RELOAD = HZ_CNT_W'(LOAD_STALL_CYC - 1);
  localparam logic [HZ_CNT_W-1:0] CTRL_RELOAD = HZ_CNT_W'(CTRL_STALL_CYC - 1);

  hz_state_e             state;
  hz_state_e             state_nx;
  logic [HZ_CNT_W-1:0]   cnt;
  logic                  cnt_done;
  logic                  cnt_clr;
  logic                  cnt_load;
  logic [HZ_CNT_W-1:0]   cnt_load_val;
  logic                  cnt_dec;
  logic                  lu;
  logic                  ch;
  logic                  redirect;

  hazard_down_counter #(
    .W (HZ_CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .done     (cnt_done)
  );

  assign lu = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
              ((id_use_rs1 & (ex_rd == id_rs1)) |
               (id_use_rs2 & (ex_rd == id_rs2)));

  assign ch       = STALL_ON_BR & id_valid & is_ctrl_opc(id_opcode);
  assign redirect = PREDICT_NT & ex_redirect;

  // Reset is folded in here so outputs hold their quiet values while rst_n
  // is low, independent of whatever state the flops currently hold.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nx     = state;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    if (!rst_n) begin
      state_nx = IDLE;
    end else if (redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_nx     = IDLE;
      cnt_clr      = 1'b1;
    end else begin
      case (state)
        LOAD_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          cnt_dec      = 1'b1;
          if (cnt_done) state_nx = IDLE;
        end
        CTRL_STALL: begin
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          cnt_dec     = 1'b1;
          if (cnt_done) state_nx = IDLE;
        end
        default: begin
          if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_MULTI) begin
              state_nx     = LOAD_STALL;
              cnt_load     = 1'b1;
              cnt_load_val = LOAD_RELOAD;
            end
          end else if (ch) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            if (CTRL_MULTI) begin
              state_nx     = CTRL_STALL;
              cnt_load     = 1'b1;
              cnt_load_val = CTRL_RELOAD;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_write) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  assign busy = rst_n & (state != IDLE);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Three differently parameterised hazard units driven with shared directed
// and random stimulus, checked against a pending-stall-cycles reference model.
module tb_hazard_ctrl_unit;

  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam int K_LOAD = 1;
  localparam int K_CTRL = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_valid, ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_redirect;

  logic        o_pc[3], o_ifw[3], o_fl[3], o_bub[3], o_busy[3];
  logic [31:0] sc0;
  logic [3:0]  sc1;
  logic [7:0]  sc2;
  logic [63:0] o_sc[3];

  assign o_sc[0] = {32'b0, sc0};
  assign o_sc[1] = {60'b0, sc1};
  assign o_sc[2] = {56'b0, sc2};

  always #5 clk = ~clk;

  // u0: defaults; u1: 3-cycle load stall, 4-bit counter; u2: predict-not-taken
  hazard_ctrl_unit u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_write(o_pc[0]), .if_id_write(o_ifw[0]), .if_id_flush(o_fl[0]),
    .id_ex_bubble(o_bub[0]), .busy(o_busy[0]), .stall_cnt(sc0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYC(3), .CTRL_STALL_CYC(2), .BR_MODE(0), .PERF_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_write(o_pc[1]), .if_id_write(o_ifw[1]), .if_id_flush(o_fl[1]),
    .id_ex_bubble(o_bub[1]), .busy(o_busy[1]), .stall_cnt(sc1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL_CYC(3), .CTRL_STALL_CYC(3), .BR_MODE(1), .PERF_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_write(o_pc[2]), .if_id_write(o_ifw[2]), .if_id_flush(o_fl[2]),
    .id_ex_bubble(o_bub[2]), .busy(o_busy[2]), .stall_cnt(sc2));

  function automatic int lcyc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction
  function automatic int ccyc(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int bmode(input int i);
    return (i == 2) ? 1 : 0;
  endfunction
  function automatic int pw(input int i);
    return (i == 0) ? 32 : ((i == 1) ? 4 : 8);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  // Model: number of stall cycles still owed and what kind they are.
  int     rem[3];
  int     kind[3];
  longint msc[3];

  logic        s_pc[3], s_ifw[3], s_fl[3], s_bub[3], s_busy[3];
  logic [63:0] s_sc[3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_nop();
    id_valid = 1'b0; id_opcode = OP_ADD; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
  endtask

  task automatic set_id(input logic [6:0] op, input int r1, input int r2, input logic u1, input logic u2);
    id_valid = 1'b1; id_opcode = op; id_rs1 = 5'(r1); id_rs2 = 5'(r2);
    id_use_rs1 = u1; id_use_rs2 = u2;
  endtask

  task automatic set_ex_load(input int rd);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'(rd);
  endtask

  task automatic step();
    bit lu, is_ctrl;
    bit e_pc, e_ifw, e_fl, e_bub, e_busy;
    @(negedge clk);
    lu = ex_valid && ex_mem_read && (ex_rd != 0) && id_valid &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    is_ctrl = id_valid && (id_opcode == OP_BEQ || id_opcode == OP_JALR);
    for (int i = 0; i < 3; i++) begin
      e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
      e_busy = rst_n && (rem[i] > 0);
      if (!rst_n) begin
        rem[i] = 0;
      end else if (bmode(i) == 1 && ex_redirect) begin
        e_fl = 1; e_bub = 1; rem[i] = 0;
      end else if (rem[i] > 0) begin
        e_pc = 0;
        if (kind[i] == K_LOAD) begin e_ifw = 0; e_bub = 1; end
        else e_fl = 1;
        rem[i]--;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
        rem[i] = lcyc(i) - 1; kind[i] = K_LOAD;
      end else if (bmode(i) == 0 && is_ctrl) begin
        e_pc = 0; e_fl = 1;
        rem[i] = ccyc(i) - 1; kind[i] = K_CTRL;
      end
      check($sformatf("u%0d.pc_write", i), 64'(o_pc[i]), 64'(e_pc));
      check($sformatf("u%0d.if_id_write", i), 64'(o_ifw[i]), 64'(e_ifw));
      check($sformatf("u%0d.if_id_flush", i), 64'(o_fl[i]), 64'(e_fl));
      check($sformatf("u%0d.id_ex_bubble", i), 64'(o_bub[i]), 64'(e_bub));
      check($sformatf("u%0d.busy", i), 64'(o_busy[i]), 64'(e_busy));
      check($sformatf("u%0d.stall_cnt", i), o_sc[i], 64'(msc[i]));
      s_pc[i] = o_pc[i]; s_ifw[i] = o_ifw[i]; s_fl[i] = o_fl[i];
      s_bub[i] = o_bub[i]; s_busy[i] = o_busy[i]; s_sc[i] = o_sc[i];
      if (!rst_n) msc[i] = 0;
      else if (!e_pc) msc[i] = (msc[i] + 1) % (64'sd1 <<< pw(i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_nop();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rem[i] = 0; kind[i] = 0; msc[i] = 0; end
    set_nop();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check("reset.busy", 64'(s_busy[0]), 64'd0);
    check("reset.pc_write", 64'(s_pc[1]), 64'd1);

    // lw x5 in EX, add x6,x5,x1 in ID
    set_ex_load(5); set_id(OP_ADD, 5, 1, 1'b1, 1'b1);
    step();
    check("lu.pc_write", 64'(s_pc[0]), 64'd0);
    check("lu.if_id_write", 64'(s_ifw[0]), 64'd0);
    check("lu.bubble", 64'(s_bub[0]), 64'd1);
    set_nop();
    step();
    check("lu.stall_cnt", s_sc[0], 64'd1);
    check("lu3.busy_c2", 64'(s_busy[1]), 64'd1);
    step();
    check("lu3.busy_c3", 64'(s_busy[1]), 64'd1);
    check("lu3.pc_c3", 64'(s_pc[1]), 64'd0);
    step();
    check("lu3.pc_after", 64'(s_pc[1]), 64'd1);
    check("lu3.stall_cnt", s_sc[1], 64'd3);

    // no stall when ex_rd is x0 or the matching source is unused
    set_ex_load(0); set_id(OP_ADD, 0, 0, 1'b1, 1'b1);
    step();
    check("lu.rd0", 64'(s_pc[0]), 64'd1);
    set_ex_load(5); set_id(OP_ADD, 5, 1, 1'b0, 1'b1);
    step();
    check("lu.unused_rs1", 64'(s_pc[1]), 64'd1);

    // beq in ID: two cycles of fetch hold with flush; jal never stalls
    do_reset();
    set_id(OP_BEQ, 1, 2, 1'b1, 1'b1);
    step();
    check("beq.c1_flush", 64'(s_fl[0]), 64'd1);
    set_nop();
    step();
    check("beq.c2_pc", 64'(s_pc[0]), 64'd0);
    step();
    check("beq.c3_pc", 64'(s_pc[0]), 64'd1);
    set_id(OP_JAL, 0, 0, 1'b0, 1'b0);
    step();
    check("jal.pc", 64'(s_pc[0]), 64'd1);

    // lw x5 then beq x5,x0: load-use first, control hazard afterwards
    do_reset();
    set_ex_load(5); set_id(OP_BEQ, 5, 0, 1'b1, 1'b1);
    step();
    check("lubr.c1_bubble", 64'(s_bub[0]), 64'd1);
    set_nop(); set_id(OP_BEQ, 5, 0, 1'b1, 1'b1);
    step();
    check("lubr.c2_flush", 64'(s_fl[0]), 64'd1);
    set_nop();
    step();
    step();
    check("lubr.stall_cnt", s_sc[0], 64'd3);

    // redirect during LOAD_STALL cycle 2 on the predict-not-taken unit
    do_reset();
    set_ex_load(5); set_id(OP_ADD, 5, 1, 1'b1, 1'b1);
    step();
    set_nop(); ex_redirect = 1'b1;
    step();
    check("redir.pc", 64'(s_pc[2]), 64'd1);
    check("redir.flush", 64'(s_fl[2]), 64'd1);
    check("redir.bubble", 64'(s_bub[2]), 64'd1);
    ex_redirect = 1'b0;
    step();
    check("redir.busy_after", 64'(s_busy[2]), 64'd0);

    // reset asserted in the middle of a control stall
    do_reset();
    set_id(OP_BEQ, 1, 2, 1'b1, 1'b1);
    step();
    set_nop(); rst_n = 1'b0;
    step();
    check("midrst.pc", 64'(s_pc[0]), 64'd1);
    check("midrst.flush", 64'(s_fl[0]), 64'd0);
    rst_n = 1'b1;
    step();
    check("midrst.busy", 64'(s_busy[0]), 64'd0);
    check("midrst.stall_cnt", s_sc[0], 64'd0);

    // 15 load-use stalls plus 2 control stalls wrap the 4-bit counter to 1
    do_reset();
    set_ex_load(3); set_id(OP_ADD, 3, 3, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step();
    set_nop(); set_id(OP_BEQ, 1, 2, 1'b1, 1'b1);
    step();
    set_nop();
    step();
    step();
    check("wrap.stall_cnt", s_sc[1], 64'd1);

    for (int k = 0; k < 600; k++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 4))
        0: id_opcode = OP_BEQ;
        1: id_opcode = OP_JALR;
        2: id_opcode = OP_JAL;
        3: id_opcode = OP_LW;
        default: id_opcode = OP_ADD;
      endcase
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard detection and pipeline control for the 5-stage RV32 core. It sits beside the ID stage and drives PC write-enable, IF/ID hold and flush, and ID/EX bubble insertion. It handles load-use stalls of configurable length, and control hazards in one of two modes: legacy stall-on-branch, or predict-not-taken with a redirect flush. It also keeps a stall-cycle performance counter.

Parameters:
REG_AW, 5, register address width
LOAD_STALL_CYC, 1, bubble cycles inserted per load-use hazard (1..7)
CTRL_STALL_CYC, 2, fetch-hold cycles per control instruction in mode 0 (1..7)
BR_MODE, 0, 0 = stall on BRANCH/JALR in ID; 1 = predict-not-taken, flush on ex_redirect
PERF_W, 32, stall counter width

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  ID instruction opcode
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_valid  in  1  EX holds a real instruction
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  REG_AW  EX destination
ex_redirect  in  1  EX resolved taken branch/jalr (used only when BR_MODE=1)
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
busy  out  1  FSM not in IDLE
stall_cnt  out  PERF_W  cycles with pc_write=0 since reset

Behaviour:
- FSM states: IDLE, LOAD_STALL, CTRL_STALL. A down-counter cnt of width $clog2(8) holds the remaining cycles.
- Reset: any rising clk edge with rst_n=0 sets state=IDLE, cnt=0, stall_cnt=0. While rst_n=0, outputs are forced to pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, busy=0.
- Outputs are combinational from state, cnt and inputs; stall_cnt is registered.
- Load-use hit (lu) requires all of:
  - ex_valid & ex_mem_read & (ex_rd != 0) & id_valid
  - ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))
- Control hit (ch) = (BR_MODE==0) & id_valid & (id_opcode==BRANCH | id_opcode==JALR). JAL never hits, because its target resolves in ID.
- Priority, highest first: reset > ex_redirect (mode 1) > active state > lu > ch.
- ex_redirect (BR_MODE=1):
  - Outputs for that cycle: pc_write=1, if_id_flush=1, id_ex_bubble=1, if_id_write=1.
  - Next state is IDLE and cnt=0, aborting any LOAD_STALL in progress.
  - Ignored when BR_MODE=0.
- IDLE & lu:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If LOAD_STALL_CYC>1, go to LOAD_STALL with cnt=LOAD_STALL_CYC-1; otherwise stay IDLE.
- LOAD_STALL:
  - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
  - cnt decrements each cycle; on the cycle cnt==1, next state is IDLE.
  - Neither lu nor ch is evaluated in this state.
- IDLE & ch & !lu:
  - Outputs: pc_write=0, if_id_flush=1; the branch advances to EX.
  - If CTRL_STALL_CYC>1, go to CTRL_STALL with cnt=CTRL_STALL_CYC-1.
- CTRL_STALL:
  - Outputs: pc_write=0, if_id_flush=1.
  - cnt decrements; on the cycle cnt==1, next state is IDLE.
- Simultaneous lu and ch (a branch that reads a loaded register): lu wins. ch is re-evaluated in IDLE after the stall ends.
- Otherwise: pc_write=1, if_id_write=1, no flush, no bubble.
- busy = (state != IDLE).
- stall_cnt increments every cycle pc_write==0 and wraps modulo 2^PERF_W.
- Out-of-range parameter values are a fatal error at elaboration.

Decomposition:
- Shared package riscv_pkg:
  - opcode constants OPC_BRANCH=7'b1100011, OPC_JALR=7'b1100111, OPC_JAL=7'b1101111, OPC_LOAD=7'b0000011
  - hazard state enum {IDLE, LOAD_STALL, CTRL_STALL}
- One sub-module, hazard_down_counter: loadable down-counter with a done pulse, instantiated once.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID, defaults → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1.
- Same stimulus with LOAD_STALL_CYC=3 → stall lasts exactly 3 cycles and busy=1 for cycles 2-3; ex_rd=0 or id_use_rs1=0 → no stall.
- BR_MODE=0, beq in ID → pc_write=0 and if_id_flush=1 for exactly 2 cycles; jal in ID → no stall.
- BR_MODE=0, lw x5 in EX with beq x5,x0 in ID → 1 load-use cycle, then 2 control cycles (3 total); stall_cnt=3.
- BR_MODE=1, LOAD_STALL_CYC=3, ex_redirect asserted in LOAD_STALL cycle 2 → that cycle pc_write=1, if_id_flush=1, id_ex_bubble=1; next cycle IDLE with busy=0.
- Assert rst_n=0 mid-CTRL_STALL → state IDLE and stall_cnt=0 after the edge; outputs at reset values while rst_n=0; PERF_W=4 with 17 stall cycles → stall_cnt=1.
